// File: rtl/ysyx_22050550_isram.sv
// ---------------------------------------------------------------------------
// ysyx_22050550_isram
//
// Instruction-memory responder at the far end of the fetch path. Accepts one
// PC-addressed fetch at a time, waits a fixed access latency and returns the
// instruction word. Misaligned or out-of-range fetches return a NOP
// (addi x0,x0,0) with rsp_err set, so the pipeline never stalls on a bad PC.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (array contents are kept)
//   req_valid  : fetch request present
//   req_ready  : responder idle and able to accept a request
//   req_addr   : fetch byte address (PC)
//   rsp_valid  : response present
//   rsp_ready  : IFU accepts the response
//   rsp_inst   : instruction word (held stable while rsp_valid && !rsp_ready)
//   rsp_err    : fetch was misaligned or out of range
//   ld_en      : preload write enable, honoured in every state and in reset
//   ld_addr    : word index to preload
//   ld_data    : word to preload
// ---------------------------------------------------------------------------
module ysyx_22050550_isram #(
    parameter int                ADDR_W  = 64,
    parameter int                INST_W  = 32,
    parameter int                DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE    = 64'h8000_0000,
    parameter int                LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [INST_W-1:0]        rsp_inst,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [INST_W-1:0]        ld_data
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [INST_W-1:0] NOP   = INST_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic                capture;

    logic [ADDR_W-1:0]   cap_addr;
    logic [ADDR_W-1:0]   cap_off;
    logic [ADDR_W-1:0]   cap_word;
    logic                cap_err;
    logic [IDX_W-1:0]    cap_idx;

    logic [INST_W-1:0]   mem [DEPTH];
    logic [INST_W-1:0]   rd_data_reg;
    logic                rsp_valid_reg;
    logic                rsp_err_reg;
    logic                data_ok_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_next = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // Single-cycle build captures straight off the request bus.
                        state_next = S_RESP;
                        capture    = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = S_RESP;
                    capture    = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_reg == S_IDLE && req_valid) begin
            addr_reg <= req_addr;
        end
    end

    // ------------------------------------------------------------------
    // Address check. Full-width arithmetic: a PC far above the array must
    // not alias back into range through truncation.
    // ------------------------------------------------------------------
    assign cap_addr = (state_reg == S_IDLE) ? req_addr : addr_reg;
    assign cap_off  = cap_addr - BASE;
    assign cap_word = cap_off >> 2;
    assign cap_err  = (cap_addr[1:0] != 2'b00) ||
                      (cap_addr < BASE) ||
                      (cap_word >= ADDR_W'(DEPTH));
    assign cap_idx  = cap_word[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Instruction array: write port for preload, registered read port that
    // fires only on the capture edge. Read-before-write ordering means a
    // preload hitting the captured index on the same edge returns the old
    // word. Contents are deliberately outside the reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (capture) begin
            rd_data_reg <= mem[cap_idx];
        end
    end

    // ------------------------------------------------------------------
    // Response flags. data_ok_reg qualifies rd_data_reg so that the array
    // read register needs no reset of its own.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            data_ok_reg   <= 1'b0;
        end else if (capture) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= cap_err;
            data_ok_reg   <= !cap_err;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign req_ready = (state_reg == S_IDLE) && !rst;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_inst  = data_ok_reg ? rd_data_reg : (rsp_err_reg ? NOP : '0);

endmodule

// File: tb/tb_ysyx_22050550_isram.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050550_isram
//
// Two responders share clock, reset and preload port: dut 0 built with
// LATENCY=2, dut 1 with LATENCY=1. A word-array model holds the expected
// contents; expected responses come from the address rules directly.
// ---------------------------------------------------------------------------
module tb_ysyx_22050550_isram;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic        req_valid_s [2];
    logic [63:0] req_addr_s  [2];
    logic        rsp_ready_s [2];
    logic        req_ready_s [2];
    logic        rsp_valid_s [2];
    logic [31:0] rsp_inst_s  [2];
    logic        rsp_err_s   [2];

    logic [31:0] model_mem [DEPTH];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_acc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22050550_isram #(.LATENCY(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_addr(req_addr_s[0]),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
        .rsp_inst(rsp_inst_s[0]), .rsp_err(rsp_err_s[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ysyx_22050550_isram #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_addr(req_addr_s[1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
        .rsp_inst(rsp_inst_s[1]), .rsp_err(rsp_err_s[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic addr_bad(input logic [63:0] a);
        return (a % 4 != 0) || (a < BASE) || ((a - BASE) / 4 >= 64'(DEPTH));
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        logic [63:0] w;
        w = (a - BASE) / 4;
        return int'(w % DEPTH);
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic load(input int idx, input logic [31:0] val);
        ld_en   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = val;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        model_mem[idx] = val;
        @(negedge clk);
    endtask

    // One fetch on dut d. Called at a negedge; returns at a negedge with the
    // responder back in IDLE. ld_c >= 0 drives a preload of ld_idx/ld_v at
    // that many edges after the accept edge while the fetch is in flight.
    task automatic fetch(input int d, input logic [63:0] a, input int hold,
                         input int ld_c, input int ld_idx, input logic [31:0] ld_v,
                         input bit chk_gap);
        logic [31:0] e_inst;
        logic        e_err;
        int          c;
        int          w;
        int          lat;
        int          acc;
        int          hidx;
        lat = lat_of(d);
        w = 0;
        while (!req_ready_s[d] && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_before", req_ready_s[d], 1);
        req_valid_s[d] = 1'b1;
        req_addr_s[d]  = a;
        rsp_ready_s[d] = 1'b0;
        e_err  = addr_bad(a);
        e_inst = e_err ? 32'h0000_0013 : model_mem[idx_of(a)];
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid_s[d] = 1'b0;
        req_addr_s[d]  = {$urandom, $urandom};
        if (chk_gap) check("accept_gap", 64'(acc - last_acc[d]), 64'(lat + 1));
        last_acc[d] = acc;
        // Ignored-request probe: valid held high while busy must not matter.
        req_valid_s[d] = 1'b1;
        c = 0;
        @(negedge clk);
        while (!rsp_valid_s[d] && c < 40) begin
            check("ready_busy", req_ready_s[d], 0);
            if (c == ld_c) begin
                ld_en   = 1'b1;
                ld_addr = 10'(ld_idx);
                ld_data = ld_v;
                // A load lands before the capture edge only if it is earlier
                // than edge LATENCY-1 after accept.
                if (!e_err && ld_idx == idx_of(a) && (c + 1) < (lat - 1)) e_inst = ld_v;
            end
            @(posedge clk);
            #1;
            if (ld_en) begin
                model_mem[ld_idx] = ld_v;
                ld_en = 1'b0;
            end
            c++;
            @(negedge clk);
        end
        req_valid_s[d] = 1'b0;
        check("latency", 64'(c), 64'(lat - 1));
        check("rsp_inst", rsp_inst_s[d], e_inst);
        check("rsp_err", rsp_err_s[d], e_err);
        check("ready_in_resp", req_ready_s[d], 0);
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                // Overwrite the word being returned: response must not move.
                hidx = e_err ? int'($urandom_range(0, DEPTH - 1)) : idx_of(a);
                ld_en   = 1'b1;
                ld_addr = 10'(hidx);
                ld_data = $urandom;
            end
            @(posedge clk);
            #1;
            if (ld_en) begin
                model_mem[hidx] = ld_data;
                ld_en = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", rsp_valid_s[d], 1);
            check("hold_inst", rsp_inst_s[d], e_inst);
            check("hold_err", rsp_err_s[d], e_err);
            check("hold_ready", req_ready_s[d], 0);
        end
        rsp_ready_s[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_s[d] = 1'b0;
        @(negedge clk);
        check("after_hs_valid", rsp_valid_s[d], 0);
        check("after_hs_ready", req_ready_s[d], 1);
        $display("fetch dut%0d addr=%h hold=%0d inst=%h err=%0d lat=%0d", d, a, hold,
                 e_inst, e_err, c + 1);
    endtask

    initial begin
        logic [63:0] a;
        int          d;
        int          prev_d;
        int          hold;
        int          prev_hold;
        bit          loaded;
        int          ld_c;
        int          ld_idx;

        rst = 1'b1;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        for (int k = 0; k < 2; k++) begin
            req_valid_s[k] = 1'b0;
            req_addr_s[k]  = '0;
            rsp_ready_s[k] = 1'b0;
            last_acc[k]    = 0;
        end

        // Preload the whole array while held in reset.
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       load(i, 32'h0010_0093);
                1:       load(i, 32'h0020_0113);
                5:       load(i, 32'hAAAA_AAAA);
                default: load(i, $urandom);
            endcase
        end
        for (int k = 0; k < 2; k++) begin
            check("rst_req_ready", req_ready_s[k], 0);
            check("rst_rsp_valid", rsp_valid_s[k], 0);
            check("rst_rsp_inst", rsp_inst_s[k], 0);
            check("rst_rsp_err", rsp_err_s[k], 0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("post_rst_ready", req_ready_s[k], 1);
            check("post_rst_valid", rsp_valid_s[k], 0);
            check("post_rst_inst", rsp_inst_s[k], 0);
        end
        @(negedge clk);

        // Back-to-back pair, then backpressure.
        fetch(0, BASE,       0, -1, 0, 0, 0);
        fetch(0, BASE + 4,   0, -1, 0, 0, 1);
        fetch(0, BASE + 4,   5, -1, 0, 0, 0);

        // Error cases, including one that would alias if truncated to 32 bits.
        fetch(0, BASE + 2,             0, -1, 0, 0, 0);
        fetch(0, BASE + 64'h1000,      0, -1, 0, 0, 0);
        fetch(0, 64'h7FFF_FFFC,        0, -1, 0, 0, 0);
        fetch(1, 64'h1_8000_0000,      0, -1, 0, 0, 0);

        // Reset while in WAIT discards the fetch.
        req_valid_s[0] = 1'b1;
        req_addr_s[0]  = BASE + 8;
        @(posedge clk);
        #1;
        req_valid_s[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", req_ready_s[0], 0);
        check("rst_mid_valid", rsp_valid_s[0], 0);
        @(negedge clk);
        check("rst_mid_valid2", rsp_valid_s[0], 0);
        rst = 1'b0;
        #1;
        check("rst_mid_ready_after", req_ready_s[0], 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid_s[0], 0);
        end
        fetch(0, BASE + 8, 0, -1, 0, 0, 0);

        // Preload colliding with the capture edge: old word returned.
        fetch(0, BASE + 20, 0, 0, 5, 32'h5555_5555, 0);
        fetch(0, BASE + 20, 0, -1, 0, 0, 0);
        check("collision_stored", model_mem[5], 32'h5555_5555);

        // Single-cycle build back-to-back.
        fetch(1, BASE,      0, -1, 0, 0, 0);
        fetch(1, BASE + 4,  0, -1, 0, 0, 1);
        fetch(1, BASE + 20, 0, -1, 0, 0, 1);

        // Randomised traffic.
        prev_d = 1;
        prev_hold = 0;
        for (int t = 0; t < 150; t++) begin
            d = int'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 4 + 64'($urandom_range(1, 3));
                1: a = BASE - 64'($urandom_range(1, 100)) * 4;
                2: a = BASE + 64'(DEPTH * 4) + 64'($urandom_range(0, 1000)) * 4;
                3: a = {32'($urandom_range(1, 32'hFFFF_FFFF)), 32'h8000_0000}
                       + 64'($urandom_range(0, DEPTH - 1)) * 4;
                default: a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 4;
            endcase
            loaded = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                load(int'($urandom_range(0, DEPTH - 1)), $urandom);
                loaded = 1'b1;
            end
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            ld_c = ($urandom_range(0, 2) == 0) ? 0 : -1;
            ld_idx = (!addr_bad(a) && $urandom_range(0, 1) == 1) ? idx_of(a)
                                                               : int'($urandom_range(0, DEPTH - 1));
            fetch(d, a, hold, ld_c, ld_idx, $urandom,
                  (d == prev_d) && (prev_hold == 0) && !loaded);
            prev_d = d;
            prev_hold = hold;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
